cic_gain_controller: RTL
========================

CIC_GAIN_CONTROLLER -- requirements
Module: cic_gain_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: width of the decimated CIC sample.
REQ-002 SHALL have parameter GAIN_WIDTH, default 8: width of the gain code driven to the CIC.
REQ-003 SHALL have parameter WINDOW_LEN, default 64: decimated samples per measurement window.
REQ-004 SHALL have parameter SETTLE_SAMPLES, default 6: decimated samples ignored after a gain change.
REQ-005 SHALL have parameter HIGH_THRESH, default 1536: peak magnitude at or above which gain is decreased.
REQ-006 SHALL have parameter LOW_THRESH, default 512: peak magnitude below which gain is increased.
REQ-007 SHALL have parameter GAIN_MAX, default 52: largest gain code ever driven.
REQ-008 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-009 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-010 SHALL have port enable, input, 1: 1 = automatic gain control, 0 = manual.
REQ-011 SHALL have port manual_gain, input, GAIN_WIDTH: gain in manual mode and starting gain for automatic mode.
REQ-012 SHALL have port data_in, input, signed DATA_WIDTH: CIC decimated output.
REQ-013 SHALL have port data_clk, input, 1: CIC decimated-sample clock, synchronous to clk.
REQ-014 SHALL have port gain, output, GAIN_WIDTH: registered gain code to the CIC.
REQ-015 SHALL have port gain_update, output, 1: one-cycle pulse when gain changes in automatic mode.
REQ-016 SHALL have port peak, output, DATA_WIDTH-1: registered peak magnitude of the last completed window.
REQ-017 SHALL have port state, output, 2: current FSM state (IDLE=0, MEASURE=1, DECIDE=2, SETTLE=3).

Function
REQ-018 Sample strobe SHALL be asserted in the clk cycle where data_clk=1 and its registered previous value is 0; data_in SHALL be sampled in that cycle.
REQ-019 Magnitude SHALL be |data_in|, saturated to 2^(DATA_WIDTH-1)-1; the most negative input gives 2047 at default width.
REQ-020 IDLE: gain = manual_gain (registered, 1-cycle latency); counters cleared; go to MEASURE on the first cycle enable=1, loading gain from manual_gain.
REQ-021 MEASURE: on each strobe, running peak = max(running peak, magnitude) and sample count increments; on the strobe that completes WINDOW_LEN samples, go to DECIDE next cycle.
REQ-022 DECIDE, exactly one cycle: peak output <= window peak; if peak >= HIGH_THRESH and gain > 0, gain - 1; else if peak < LOW_THRESH and gain < GAIN_MAX, gain + 1; else gain unchanged.
REQ-023 gain_update SHALL pulse in the cycle the new gain appears on gain, and only if the value changed.
REQ-024 From DECIDE, go to SETTLE if gain changed, else to MEASURE; running peak and sample count SHALL be cleared on both transitions.
REQ-025 SETTLE: count strobes without measuring; after SETTLE_SAMPLES strobes go to MEASURE.
REQ-026 Gain SHALL saturate at 0 and GAIN_MAX; it never wraps and never exceeds GAIN_MAX, even if manual_gain > GAIN_MAX (clamp on load in automatic mode).
REQ-027 enable=0 in any non-IDLE state SHALL force IDLE on the next cycle, abandoning the partial window or settle count; gain then tracks manual_gain.
REQ-028 A strobe coinciding with DECIDE SHALL NOT be counted in any window or settle count.
REQ-029 A strobe coinciding with an enable 0->1 transition SHALL NOT be counted.
REQ-030 The strobe detector SHALL operate in all states so that edge history stays valid.

Reset
REQ-031 rst=1 SHALL, at the next clk edge, set state=IDLE, gain=0, gain_update=0, peak=0, clear all counters, running peak and previous data_clk; rst takes priority over all other inputs.
REQ-032 rst asserted mid-window or mid-settle SHALL discard all progress; after release the block follows REQ-020.

Verification
REQ-033 Manual: enable=0, manual_gain=20 -> gain=20 one cycle later; no gain_update pulse; state=0.
REQ-034 Loud input: enable=1, manual_gain=20, constant data_in=1800 at one strobe per 16 clk -> after 64 strobes, peak=1800, gain=19, one gain_update pulse, state=SETTLE for 6 strobes.
REQ-035 Quiet input at the upper bound: manual_gain=52, data_in=100 -> peak=100, gain stays 52, no pulse, direct return to MEASURE.
REQ-036 Saturation and floor: data_in=-2048 with gain=0 -> peak=2047, gain stays 0, no pulse.
REQ-037 Abort: drop enable after 30 strobes of a window -> IDLE next cycle, gain=manual_gain; re-enable -> full 64-strobe window is required before a decision.
REQ-038 Reset mid-settle: rst for 1 cycle -> gain=0, peak=0, state=IDLE the next cycle.

Source files
------------

// File: rtl/cic_gain_controller_if.sv
// ---------------------------------------------------------------------------
// cic_gain_controller_if
//
// Purpose: bundles the sample-side and gain-side signals of the CIC gain
// controller so the controller and its environment connect through a single
// port.
//
// Signals:
//   enable      : 1 = automatic gain control, 0 = manual gain
//   manual_gain : manual gain, also the starting gain for automatic mode
//   data_in     : signed decimated CIC sample
//   data_clk    : decimated-sample clock, synchronous to clk
//   gain        : registered gain code driven to the CIC
//   gain_update : one-cycle pulse when automatic mode changes the gain
//   peak        : registered peak magnitude of the last completed window
//   state       : controller FSM state (IDLE=0, MEASURE=1, DECIDE=2, SETTLE=3)
//
// Transfer semantics: there is no valid/ready pair. A sample is transferred
// in the clk cycle where data_clk is 1 and was 0 in the previous cycle;
// data_in must be stable in that cycle. The controller cannot stall the
// source, so every such rising edge is one sample. gain/gain_update/peak/state
// are plain registered outputs with no acknowledge.
// ---------------------------------------------------------------------------
interface cic_gain_controller_if #(
    parameter int DATA_WIDTH = 12,
    parameter int GAIN_WIDTH = 8
);
    logic                         enable;
    logic [GAIN_WIDTH-1:0]        manual_gain;
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         data_clk;
    logic [GAIN_WIDTH-1:0]        gain;
    logic                         gain_update;
    logic [DATA_WIDTH-2:0]        peak;
    logic [1:0]                   state;

    // Environment side: drives samples and mode, observes gain and status.
    modport master (
        output enable, manual_gain, data_in, data_clk,
        input  gain, gain_update, peak, state
    );

    // Controller side.
    modport slave (
        input  enable, manual_gain, data_in, data_clk,
        output gain, gain_update, peak, state
    );
endinterface

// File: rtl/cic_gain_controller.sv
// ---------------------------------------------------------------------------
// cic_gain_controller
//
// Purpose: automatic gain control for a CIC decimator. Measures the peak
// magnitude of the decimated output over fixed windows of WINDOW_LEN samples
// and steps the CIC gain code down when the peak is too high or up when it is
// too low. After each gain change SETTLE_SAMPLES samples are skipped so the
// filter can settle before the next window starts. With enable low the gain
// simply follows manual_gain.
//
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   bus : cic_gain_controller_if.slave (enable, manual_gain, data_in,
//         data_clk in; gain, gain_update, peak, state out)
// ---------------------------------------------------------------------------
module cic_gain_controller #(
    parameter int DATA_WIDTH     = 12,
    parameter int GAIN_WIDTH     = 8,
    parameter int WINDOW_LEN     = 64,
    parameter int SETTLE_SAMPLES = 6,
    parameter int HIGH_THRESH    = 1536,
    parameter int LOW_THRESH     = 512,
    parameter int GAIN_MAX       = 52
) (
    input logic                    clk,
    input logic                    rst,
    cic_gain_controller_if.slave   bus
);

    localparam int PW      = DATA_WIDTH - 1;
    localparam int CNT_MAX = (WINDOW_LEN > SETTLE_SAMPLES) ? WINDOW_LEN : SETTLE_SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_DECIDE  = 2'd2,
        S_SETTLE  = 2'd3
    } state_t;

    state_t                state_q;
    logic                  dclk_q;
    logic [GAIN_WIDTH-1:0] gain_q;
    logic                  gain_update_q;
    logic [PW-1:0]         peak_q;
    logic [PW-1:0]         run_peak_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  strobe;
    logic [DATA_WIDTH-1:0] abs_v;
    logic [PW-1:0]         mag;
    logic [PW-1:0]         run_peak_d;
    logic [GAIN_WIDTH-1:0] load_gain_d;
    logic [GAIN_WIDTH-1:0] decide_gain_d;

    always_comb begin
        strobe = bus.data_clk & ~dclk_q;

        // Two's-complement absolute value; only the most negative code keeps
        // its sign bit set afterwards, and that one saturates to full scale.
        abs_v = bus.data_in[DATA_WIDTH-1] ? (~bus.data_in + 1'b1) : bus.data_in;
        mag   = abs_v[DATA_WIDTH-1] ? {PW{1'b1}} : abs_v[PW-1:0];

        run_peak_d = (mag > run_peak_q) ? mag : run_peak_q;

        // Automatic mode never starts above the gain ceiling.
        load_gain_d = (bus.manual_gain > GAIN_WIDTH'(GAIN_MAX))
                      ? GAIN_WIDTH'(GAIN_MAX) : bus.manual_gain;

        decide_gain_d = gain_q;
        if (run_peak_q >= PW'(HIGH_THRESH) && gain_q != '0) begin
            decide_gain_d = gain_q - 1'b1;
        end else if (run_peak_q < PW'(LOW_THRESH) && gain_q < GAIN_WIDTH'(GAIN_MAX)) begin
            decide_gain_d = gain_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            dclk_q        <= 1'b0;
            gain_q        <= '0;
            gain_update_q <= 1'b0;
            peak_q        <= '0;
            run_peak_q    <= '0;
            cnt_q         <= '0;
        end else begin
            // Edge history runs in every state so the first strobe after
            // leaving IDLE is detected correctly.
            dclk_q        <= bus.data_clk;
            gain_update_q <= 1'b0;

            if (state_q != S_IDLE && !bus.enable) begin
                // Abort: drop any partial window or settle count.
                state_q    <= S_IDLE;
                gain_q     <= bus.manual_gain;
                run_peak_q <= '0;
                cnt_q      <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        run_peak_q <= '0;
                        cnt_q      <= '0;
                        if (bus.enable) begin
                            // A strobe in this cycle is deliberately not counted.
                            state_q <= S_MEASURE;
                            gain_q  <= load_gain_d;
                        end else begin
                            gain_q  <= bus.manual_gain;
                        end
                    end

                    S_MEASURE: begin
                        if (strobe) begin
                            run_peak_q <= run_peak_d;
                            cnt_q      <= cnt_q + 1'b1;
                            if (cnt_q == CNT_W'(WINDOW_LEN - 1)) begin
                                state_q <= S_DECIDE;
                            end
                        end
                    end

                    S_DECIDE: begin
                        // Any strobe in this cycle is dropped.
                        peak_q     <= run_peak_q;
                        gain_q     <= decide_gain_d;
                        run_peak_q <= '0;
                        cnt_q      <= '0;
                        if (decide_gain_d != gain_q) begin
                            gain_update_q <= 1'b1;
                            state_q       <= S_SETTLE;
                        end else begin
                            state_q       <= S_MEASURE;
                        end
                    end

                    S_SETTLE: begin
                        if (strobe) begin
                            if (cnt_q == CNT_W'(SETTLE_SAMPLES - 1)) begin
                                cnt_q   <= '0;
                                state_q <= S_MEASURE;
                            end else begin
                                cnt_q   <= cnt_q + 1'b1;
                            end
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.gain        = gain_q;
    assign bus.gain_update = gain_update_q;
    assign bus.peak        = peak_q;
    assign bus.state       = state_q;

endmodule
